regfile_wb_ctrl: RTL and testbench

Writeback controller that drives both write ports of the integer register file and tracks outstanding loads. It registers single-cycle ALU results onto write port A. It keeps an in-order queue of destination registers for issued loads and writes returning load data onto write port B. It also flags read-after-write and write-after-write hazards against pending loads and in-flight writebacks, so decode can stall.

---
 rtl/regfile_wb_ctrl.sv | 130 +++++++++++++
 tb/tb_regfile_wb_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_ctrl.sv
// Writeback controller for the integer register file.
// Port A takes registered ALU results. Port B takes load data, returned in
// issue order, matched against a circular queue of load destinations.
// hazard_o tells decode to stall while a source or destination register
// still has a write outstanding.
module regfile_wb_ctrl #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int LOAD_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          alu_valid_i,
    input  logic [ADDR_WIDTH-1:0]         alu_rd_i,
    input  logic [DATA_WIDTH-1:0]         alu_wdata_i,
    input  logic                          lsu_issue_valid_i,
    input  logic [ADDR_WIDTH-1:0]         lsu_issue_rd_i,
    output logic                          lsu_issue_ready_o,
    input  logic                          lsu_rvalid_i,
    input  logic [DATA_WIDTH-1:0]         lsu_rdata_i,
    output logic [ADDR_WIDTH-1:0]         waddr_a_o,
    output logic [DATA_WIDTH-1:0]         wdata_a_o,
    output logic                          we_a_o,
    output logic [ADDR_WIDTH-1:0]         waddr_b_o,
    output logic [DATA_WIDTH-1:0]         wdata_b_o,
    output logic                          we_b_o,
    input  logic [ADDR_WIDTH-1:0]         raddr_a_i,
    input  logic [ADDR_WIDTH-1:0]         raddr_b_i,
    input  logic [ADDR_WIDTH-1:0]         dec_rd_i,
    input  logic                          dec_valid_i,
    output logic                          hazard_o,
    output logic [$clog2(LOAD_DEPTH):0]   pending_cnt_o,
    output logic                          resp_err_o
);

    localparam int PW = $clog2(LOAD_DEPTH);
    localparam int CW = PW + 1;

    logic [ADDR_WIDTH-1:0] lq_q [LOAD_DEPTH];
    logic [PW-1:0]         wptr_q;
    logic [PW-1:0]         rptr_q;
    logic [CW-1:0]         count_q;

    logic                  push;
    logic                  pop;
    logic                  empty_rsp;
    logic [ADDR_WIDTH-1:0] head_rd;
    logic                  alu_hits_head;
    logic [LOAD_DEPTH-1:0] ent_vld;
    logic [ADDR_WIDTH-1:0] srcs [3];

    // Ready looks only at the current count, so a pop never frees a slot
    // for an issue in the same cycle.
    assign lsu_issue_ready_o = (count_q < CW'(LOAD_DEPTH));
    assign push              = lsu_issue_valid_i & lsu_issue_ready_o;
    assign pop               = lsu_rvalid_i & (count_q != '0);
    assign empty_rsp         = lsu_rvalid_i & (count_q == '0);
    assign head_rd           = lq_q[rptr_q];
    assign alu_hits_head     = alu_valid_i && (alu_rd_i == head_rd);
    assign pending_cnt_o     = count_q;

    assign srcs[0] = raddr_a_i;
    assign srcs[1] = raddr_b_i;
    assign srcs[2] = dec_rd_i;

    // Load destination queue; pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LOAD_DEPTH; i++) lq_q[i] <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                lq_q[wptr_q] <= lsu_issue_rd_i;
                wptr_q       <= wptr_q + PW'(1);
            end
            if (pop) rptr_q <= rptr_q + PW'(1);
            if (push && !pop)      count_q <= count_q + CW'(1);
            else if (pop && !push) count_q <= count_q - CW'(1);
        end
    end

    // Registered write ports. The ALU result is younger, so on an address
    // collision the load write is suppressed rather than racing in the RF.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            waddr_a_o  <= '0;
            wdata_a_o  <= '0;
            we_a_o     <= 1'b0;
            waddr_b_o  <= '0;
            wdata_b_o  <= '0;
            we_b_o     <= 1'b0;
            resp_err_o <= 1'b0;
        end else begin
            we_a_o <= alu_valid_i && (alu_rd_i != '0);
            if (alu_valid_i) begin
                waddr_a_o <= alu_rd_i;
                wdata_a_o <= alu_wdata_i;
            end
            we_b_o <= pop && (head_rd != '0) && !alu_hits_head;
            if (pop) begin
                waddr_b_o <= head_rd;
                wdata_b_o <= lsu_rdata_i;
            end
            resp_err_o <= empty_rsp;
        end
    end

    // Queue slot i is live when its distance from the read pointer is below count.
    always_comb begin
        ent_vld = '0;
        for (int i = 0; i < LOAD_DEPTH; i++)
            ent_vld[i] = (CW'(PW'(PW'(i) - rptr_q)) < count_q);
    end

    // Stall decode if any nonzero operand matches a pending or in-flight write.
    always_comb begin
        hazard_o = 1'b0;
        for (int s = 0; s < 3; s++) begin
            if (dec_valid_i && (srcs[s] != '0)) begin
                if (we_a_o && (waddr_a_o == srcs[s])) hazard_o = 1'b1;
                if (we_b_o && (waddr_b_o == srcs[s])) hazard_o = 1'b1;
                for (int i = 0; i < LOAD_DEPTH; i++)
                    if (ent_vld[i] && (lq_q[i] == srcs[s])) hazard_o = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
module tb_regfile_wb_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        alu_valid_i = 1'b0;
    logic [4:0]  alu_rd_i = '0;
    logic [31:0] alu_wdata_i = '0;
    logic        lsu_issue_valid_i = 1'b0;
    logic [4:0]  lsu_issue_rd_i = '0;
    logic        lsu_issue_ready_o;
    logic        lsu_rvalid_i = 1'b0;
    logic [31:0] lsu_rdata_i = '0;
    logic [4:0]  waddr_a_o, waddr_b_o;
    logic [31:0] wdata_a_o, wdata_b_o;
    logic        we_a_o, we_b_o;
    logic [4:0]  raddr_a_i = '0, raddr_b_i = '0, dec_rd_i = '0;
    logic        dec_valid_i = 1'b0;
    logic        hazard_o;
    logic [2:0]  pending_cnt_o;
    logic        resp_err_o;

    regfile_wb_ctrl #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .LOAD_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .alu_valid_i(alu_valid_i), .alu_rd_i(alu_rd_i), .alu_wdata_i(alu_wdata_i),
        .lsu_issue_valid_i(lsu_issue_valid_i), .lsu_issue_rd_i(lsu_issue_rd_i),
        .lsu_issue_ready_o(lsu_issue_ready_o),
        .lsu_rvalid_i(lsu_rvalid_i), .lsu_rdata_i(lsu_rdata_i),
        .waddr_a_o(waddr_a_o), .wdata_a_o(wdata_a_o), .we_a_o(we_a_o),
        .waddr_b_o(waddr_b_o), .wdata_b_o(wdata_b_o), .we_b_o(we_b_o),
        .raddr_a_i(raddr_a_i), .raddr_b_i(raddr_b_i), .dec_rd_i(dec_rd_i),
        .dec_valid_i(dec_valid_i), .hazard_o(hazard_o),
        .pending_cnt_o(pending_cnt_o), .resp_err_o(resp_err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic av; logic [4:0] ard; logic [31:0] awd;
        logic iv; logic [4:0] ird;
        logic rv; logic [31:0] rdat;
        logic dv; logic [4:0] ra, rb, drd;
        logic e_haz, e_rdy;
        logic e_wea; logic [4:0] e_wa; logic [31:0] e_wda;
        logic e_web; logic [4:0] e_wb; logic [31:0] e_wdb;
        logic e_err; logic [2:0] e_cnt;
    } vec_t;

    int n_checks = 0;
    int n_fail = 0;

    // reference model: queue of pending destinations plus expected port state
    logic [4:0]  mq[$];
    logic        m_we_a = 0, m_we_b = 0, m_err = 0;
    logic [4:0]  m_wa = 0, m_wb = 0;
    logic [31:0] m_wda = 0, m_wdb = 0;

    vec_t tab[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t v(
        input logic av, input logic [4:0] ard, input logic [31:0] awd,
        input logic iv, input logic [4:0] ird, input logic rv, input logic [31:0] rdat,
        input logic dv, input logic [4:0] ra, input logic [4:0] rb, input logic [4:0] drd,
        input logic haz, input logic rdy,
        input logic wea, input logic [4:0] wa, input logic [31:0] wda,
        input logic web, input logic [4:0] wb, input logic [31:0] wdb,
        input logic err, input logic [2:0] cnt);
        vec_t r;
        r.av = av; r.ard = ard; r.awd = awd; r.iv = iv; r.ird = ird;
        r.rv = rv; r.rdat = rdat; r.dv = dv; r.ra = ra; r.rb = rb; r.drd = drd;
        r.e_haz = haz; r.e_rdy = rdy; r.e_wea = wea; r.e_wa = wa; r.e_wda = wda;
        r.e_web = web; r.e_wb = wb; r.e_wdb = wdb; r.e_err = err; r.e_cnt = cnt;
        return r;
    endfunction

    function automatic logic model_hit(input logic [4:0] s);
        if (s == 0) return 1'b0;
        foreach (mq[i]) if (mq[i] == s) return 1'b1;
        if (m_we_a && m_wa == s) return 1'b1;
        if (m_we_b && m_wb == s) return 1'b1;
        return 1'b0;
    endfunction

    // one clock: drive at edge+1, check combinational outputs, advance model, check flops
    task automatic step(input vec_t x, input bit tabchk);
        int   sz;
        bit   push, pop, a_ld;
        logic [4:0] hd;
        logic exp_haz;
        alu_valid_i = x.av; alu_rd_i = x.ard; alu_wdata_i = x.awd;
        lsu_issue_valid_i = x.iv; lsu_issue_rd_i = x.ird;
        lsu_rvalid_i = x.rv; lsu_rdata_i = x.rdat;
        dec_valid_i = x.dv; raddr_a_i = x.ra; raddr_b_i = x.rb; dec_rd_i = x.drd;
        #1;
        sz = mq.size();
        exp_haz = x.dv && (model_hit(x.ra) || model_hit(x.rb) || model_hit(x.drd));
        chk("hazard", hazard_o, exp_haz);
        chk("ready", lsu_issue_ready_o, sz < 4);
        chk("pending_pre", pending_cnt_o, sz);
        if (tabchk) begin
            chk("tab_hazard", hazard_o, x.e_haz);
            chk("tab_ready", lsu_issue_ready_o, x.e_rdy);
        end
        push = x.iv && (sz < 4);
        pop  = x.rv && (sz > 0);
        m_err = x.rv && (sz == 0);
        a_ld = x.av;
        m_we_a = x.av && (x.ard != 0);
        if (x.av) begin m_wa = x.ard; m_wda = x.awd; end
        m_we_b = 1'b0;
        if (pop) begin
            hd = mq.pop_front();
            m_we_b = (hd != 0) && !(x.av && x.ard == hd);
            m_wb = hd; m_wdb = x.rdat;
        end
        if (push) mq.push_back(x.ird);
        @(posedge clk);
        #1;
        chk("we_a", we_a_o, m_we_a);
        if (a_ld) begin
            chk("waddr_a", waddr_a_o, m_wa);
            chk("wdata_a", wdata_a_o, m_wda);
        end
        chk("we_b", we_b_o, m_we_b);
        if (pop) begin
            chk("waddr_b", waddr_b_o, m_wb);
            chk("wdata_b", wdata_b_o, m_wdb);
        end
        chk("resp_err", resp_err_o, m_err);
        chk("pending", pending_cnt_o, mq.size());
        if (tabchk) begin
            chk("tab_we_a", we_a_o, x.e_wea);
            if (x.e_wea) begin
                chk("tab_waddr_a", waddr_a_o, x.e_wa);
                chk("tab_wdata_a", wdata_a_o, x.e_wda);
            end
            chk("tab_we_b", we_b_o, x.e_web);
            if (x.e_web) begin
                chk("tab_waddr_b", waddr_b_o, x.e_wb);
                chk("tab_wdata_b", wdata_b_o, x.e_wdb);
            end
            chk("tab_resp_err", resp_err_o, x.e_err);
            chk("tab_pending", pending_cnt_o, x.e_cnt);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_we_a = 0; m_we_b = 0; m_err = 0;
        m_wa = 0; m_wb = 0; m_wda = 0; m_wdb = 0;
    endtask

    initial begin
        vec_t r;
        //            av ard awd            iv ird rv rdat         dv ra rb drd hz rdy wea wa wda           web wb wdb    err cnt
        tab.push_back(v(1, 5, 32'hDEADBEEF, 0, 0, 0, 0,           0, 0, 0, 0, 0, 1, 1, 5, 32'hDEADBEEF, 0, 0, 0,     0, 0));
        tab.push_back(v(1, 0, 32'h1234,     0, 0, 0, 0,           0, 0, 0, 0, 0, 1, 0, 0, 0,            0, 0, 0,     0, 0));
        tab.push_back(v(0, 0, 0,            1, 3, 0, 0,           0, 0, 0, 0, 0, 1, 0, 0, 0,            0, 0, 0,     0, 1));
        tab.push_back(v(0, 0, 0,            1, 7, 0, 0,           1, 3, 0, 0, 1, 1, 0, 0, 0,            0, 0, 0,     0, 2));
        tab.push_back(v(0, 0, 0,            1, 9, 0, 0,           0, 0, 0, 0, 0, 1, 0, 0, 0,            0, 0, 0,     0, 3));
        tab.push_back(v(0, 0, 0,            0, 0, 1, 32'h11,      0, 0, 0, 0, 0, 1, 0, 0, 0,            1, 3, 32'h11, 0, 2));
        tab.push_back(v(0, 0, 0,            0, 0, 1, 32'h22,      0, 0, 0, 0, 0, 1, 0, 0, 0,            1, 7, 32'h22, 0, 1));
        tab.push_back(v(0, 0, 0,            0, 0, 1, 32'h33,      1, 0, 0, 0, 0, 1, 0, 0, 0,            1, 9, 32'h33, 0, 0));
        tab.push_back(v(0, 0, 0,            0, 0, 0, 0,           1, 9, 0, 0, 1, 1, 0, 0, 0,            0, 0, 0,     0, 0));
        tab.push_back(v(0, 0, 0,            0, 0, 1, 32'h55,      0, 0, 0, 0, 0, 1, 0, 0, 0,            0, 0, 0,     1, 0));
        tab.push_back(v(0, 0, 0,            0, 0, 0, 0,           0, 0, 0, 0, 0, 1, 0, 0, 0,            0, 0, 0,     0, 0));
        tab.push_back(v(0, 0, 0,            1, 8, 0, 0,           0, 0, 0, 0, 0, 1, 0, 0, 0,            0, 0, 0,     0, 1));
        tab.push_back(v(0, 0, 0,            0, 0, 0, 0,           1, 0, 8, 0, 1, 1, 0, 0, 0,            0, 0, 0,     0, 1));
        tab.push_back(v(0, 0, 0,            0, 0, 1, 32'h88,      1, 0, 8, 0, 1, 1, 0, 0, 0,            1, 8, 32'h88, 0, 0));
        tab.push_back(v(0, 0, 0,            0, 0, 0, 0,           1, 0, 8, 0, 1, 1, 0, 0, 0,            0, 0, 0,     0, 0));
        tab.push_back(v(0, 0, 0,            0, 0, 0, 0,           1, 0, 8, 0, 0, 1, 0, 0, 0,            0, 0, 0,     0, 0));
        tab.push_back(v(0, 0, 0,            1, 4, 0, 0,           0, 0, 0, 0, 0, 1, 0, 0, 0,            0, 0, 0,     0, 1));
        tab.push_back(v(1, 4, 32'hAAAA,     0, 0, 1, 32'hBBBB,    0, 0, 0, 0, 0, 1, 1, 4, 32'hAAAA,     0, 0, 0,     0, 0));
        tab.push_back(v(0, 0, 0,            0, 0, 0, 0,           1, 0, 0, 4, 1, 1, 0, 0, 0,            0, 0, 0,     0, 0));
        tab.push_back(v(0, 0, 0,            1, 1, 0, 0,           0, 0, 0, 0, 0, 1, 0, 0, 0,            0, 0, 0,     0, 1));
        tab.push_back(v(0, 0, 0,            1, 2, 0, 0,           0, 0, 0, 0, 0, 1, 0, 0, 0,            0, 0, 0,     0, 2));
        tab.push_back(v(0, 0, 0,            1, 3, 0, 0,           0, 0, 0, 0, 0, 1, 0, 0, 0,            0, 0, 0,     0, 3));
        tab.push_back(v(0, 0, 0,            1, 4, 0, 0,           0, 0, 0, 0, 0, 1, 0, 0, 0,            0, 0, 0,     0, 4));
        tab.push_back(v(0, 0, 0,            1, 5, 0, 0,           0, 0, 0, 0, 0, 0, 0, 0, 0,            0, 0, 0,     0, 4));
        tab.push_back(v(0, 0, 0,            1, 6, 1, 32'h61,      0, 0, 0, 0, 0, 0, 0, 0, 0,            1, 1, 32'h61, 0, 3));

        // reset values while held in reset
        dec_valid_i = 1'b1; raddr_a_i = 5'd5;
        #3;
        chk("rst_we_a", we_a_o, 0);
        chk("rst_we_b", we_b_o, 0);
        chk("rst_waddr_a", waddr_a_o, 0);
        chk("rst_wdata_b", wdata_b_o, 0);
        chk("rst_pending", pending_cnt_o, 0);
        chk("rst_ready", lsu_issue_ready_o, 1);
        chk("rst_resp_err", resp_err_o, 0);
        chk("rst_hazard", hazard_o, 0);
        dec_valid_i = 1'b0; raddr_a_i = '0;
        #19 rst_n = 1'b1;
        @(posedge clk); #1;

        foreach (tab[i]) step(tab[i], 1'b1);

        // simultaneous push+pop across pointer wrap: count holds at 3
        for (int i = 0; i < 10; i++) begin
            r = v(0, 0, 0, 1, 5'(12 + i), 1, $urandom, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
            step(r, 1'b0);
            chk("wrap_pending", pending_cnt_o, 3);
        end
        for (int i = 0; i < 3; i++) begin
            r = v(0, 0, 0, 0, 0, 1, $urandom, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
            step(r, 1'b0);
        end

        // randomized traffic over a small register range to provoke hazards/collisions
        for (int i = 0; i < 400; i++) begin
            r = v($urandom_range(0, 1), 5'($urandom_range(0, 7)), $urandom,
                  ($urandom_range(0, 99) < 45), 5'($urandom_range(0, 7)),
                  ($urandom_range(0, 99) < 40), $urandom,
                  $urandom_range(0, 1), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                  5'($urandom_range(0, 7)), 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
            step(r, 1'b0);
        end

        // reset mid-operation with two loads pending and a port-A write in flight
        model_reset();
        rst_n = 1'b0; #2; rst_n = 1'b1;
        @(posedge clk); #1;
        step(v(1, 7, 32'hA1, 1, 10, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0);
        step(v(1, 6, 32'hA2, 1, 11, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0);
        chk("pre_rst_pending", pending_cnt_o, 2);
        alu_valid_i = 0; lsu_issue_valid_i = 0; lsu_rvalid_i = 0;
        dec_valid_i = 1; raddr_a_i = 5'd10; raddr_b_i = 0; dec_rd_i = 0;
        #3 rst_n = 1'b0;
        #1;
        chk("midrst_pending", pending_cnt_o, 0);
        chk("midrst_ready", lsu_issue_ready_o, 1);
        chk("midrst_we_a", we_a_o, 0);
        chk("midrst_we_b", we_b_o, 0);
        chk("midrst_hazard", hazard_o, 0);
        model_reset();
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        step(v(0, 0, 0, 0, 0, 1, 32'h77, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0);
        chk("post_rst_err", resp_err_o, 1);
        chk("post_rst_we_b", we_b_o, 0);
        step(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0);
        chk("post_rst_err_clear", resp_err_o, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
